// File: rtl/branch_ctrl.sv
// ============================================================================
// Module      : branch_ctrl
// Description : Decode-stage branch resolution sequencer. It holds ID until the
//               branch operands are ready, then resolves the branch on latched
//               values and sends a one-cycle redirect to fetch.
//               Optional feature macro: BRANCH_STATS_EN (branch statistics).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_ctrl #(
    parameter int MAX_WAIT   = 3,
    parameter int DELAY_SLOT = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        br_valid_i,
    input  logic [3:0]  btype_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        rs_ready_i,
    input  logic        rt_ready_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [15:0] imm16_i,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_if_o,
    output logic        br_done_o,
    output logic        hazard_timeout_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] br_total_o,
    output logic [15:0] br_taken_o
`endif
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESOLVE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic       C_FLUSH_EN = (DELAY_SLOT == 0);

    logic [1:0]  state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        hto_q, hto_d;

    logic [31:0] rs_q, rt_q;
    logic [3:0]  btype_q;
    logic [31:0] target_q;

    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic        flush_if_q;
    logic        br_done_q;

    logic        w_ready;
    logic        w_latch;
    logic        w_resolve;
    logic        w_taken;
    logic [31:0] w_target;

    // Single-operand branches (btype 2..5) never wait on rt.
    assign w_ready   = rs_ready_i & (rt_ready_i | (btype_i >= 4'd2));
    assign w_target  = pc_plus4_i + {{14{imm16_i[15]}}, imm16_i, 2'b00};
    assign w_resolve = (state_q == S_RESOLVE);
    assign w_latch   = (state_d == S_RESOLVE);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        hto_d      = hto_q;
        case (state_q)
            S_IDLE: begin
                if (br_valid_i) begin
                    if (w_ready) begin
                        state_d = S_RESOLVE;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 4'd0;
                    end
                end
            end
            S_WAIT: begin
                if (!br_valid_i) begin
                    state_d = S_IDLE;
                end else if (w_ready) begin
                    state_d = S_RESOLVE;
                end else begin
                    if (wait_cnt_q != 4'hF) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                    if (wait_cnt_d >= C_MAX_WAIT) begin
                        hto_d = 1'b1;
                    end
                end
            end
            S_RESOLVE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (btype_q)
            4'd0:    w_taken = (rs_q == rt_q);
            4'd1:    w_taken = (rs_q != rt_q);
            4'd2:    w_taken = rs_q[31] | (rs_q == 32'd0);
            4'd3:    w_taken = ~rs_q[31] & (rs_q != 32'd0);
            4'd4:    w_taken = rs_q[31];
            4'd5:    w_taken = ~rs_q[31];
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= 4'd0;
            hto_q         <= 1'b0;
            rs_q          <= 32'd0;
            rt_q          <= 32'd0;
            btype_q       <= 4'd0;
            target_q      <= 32'd0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            flush_if_q    <= 1'b0;
            br_done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            hto_q      <= hto_d;
            // Operands are captured once; later data changes cannot alter the result.
            if (w_latch) begin
                rs_q     <= rs_data_i;
                rt_q     <= rt_data_i;
                btype_q  <= btype_i;
                target_q <= w_target;
            end
            redirect_q    <= w_resolve & w_taken;
            redirect_pc_q <= (w_resolve & w_taken) ? target_q : 32'd0;
            flush_if_q    <= w_resolve & w_taken & C_FLUSH_EN;
            br_done_q     <= w_resolve;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] br_total_q;
    logic [15:0] br_taken_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            br_total_q <= 16'd0;
            br_taken_q <= 16'd0;
        end else if (w_resolve) begin
            if (br_total_q != 16'hFFFF) begin
                br_total_q <= br_total_q + 16'd1;
            end
            if (w_taken && (br_taken_q != 16'hFFFF)) begin
                br_taken_q <= br_taken_q + 16'd1;
            end
        end
    end

    assign br_total_o = br_total_q;
    assign br_taken_o = br_taken_q;
`else
    // Statistics counters are absent in this build.
`endif

    assign stall_o          = ((state_q == S_IDLE) & br_valid_i) | (state_q == S_WAIT) | w_resolve;
    assign redirect_o       = redirect_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign flush_if_o       = flush_if_q;
    assign br_done_o        = br_done_q;
    assign hazard_timeout_o = hto_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_ctrl.sv
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Self-checking bench for branch_ctrl (delay-slot and no-delay-slot
//               instances driven in lockstep). Honours BRANCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_ctrl;

    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        br_valid;
    logic [3:0]  btype;
    logic [31:0] rs_data, rt_data, pc_plus4;
    logic        rs_ready, rt_ready;
    logic [15:0] imm16;

    logic        stall1, redir1, flush1, done1, hto1;
    logic        stall0, redir0, flush0, done0, hto0;
    logic [31:0] rpc1, rpc0;
`ifdef BRANCH_STATS_EN
    logic [15:0] tot1, tkn1, tot0, tkn0;
    logic [15:0] exp_total, exp_tkn;
`endif

    int   nerr = 0;
    int   nchk = 0;
    logic exp_hto;
    int   wait_elapsed;

    always #5 clk = ~clk;

    branch_ctrl #(.MAX_WAIT(MAX_WAIT), .DELAY_SLOT(1)) dut (
        .clk_i(clk), .reset_i(reset), .br_valid_i(br_valid), .btype_i(btype),
        .rs_data_i(rs_data), .rt_data_i(rt_data), .rs_ready_i(rs_ready), .rt_ready_i(rt_ready),
        .pc_plus4_i(pc_plus4), .imm16_i(imm16), .stall_o(stall1), .redirect_o(redir1),
        .redirect_pc_o(rpc1), .flush_if_o(flush1), .br_done_o(done1), .hazard_timeout_o(hto1)
`ifdef BRANCH_STATS_EN
        , .br_total_o(tot1), .br_taken_o(tkn1)
`endif
    );

    branch_ctrl #(.MAX_WAIT(MAX_WAIT), .DELAY_SLOT(0)) dut_ns (
        .clk_i(clk), .reset_i(reset), .br_valid_i(br_valid), .btype_i(btype),
        .rs_data_i(rs_data), .rt_data_i(rt_data), .rs_ready_i(rs_ready), .rt_ready_i(rt_ready),
        .pc_plus4_i(pc_plus4), .imm16_i(imm16), .stall_o(stall0), .redirect_o(redir0),
        .redirect_pc_o(rpc0), .flush_if_o(flush0), .br_done_o(done0), .hazard_timeout_o(hto0)
`ifdef BRANCH_STATS_EN
        , .br_total_o(tot0), .br_taken_o(tkn0)
`endif
    );

    function automatic logic model_taken(input logic [3:0] bt, input logic [31:0] a, input logic [31:0] b);
        case (bt)
            4'd0:    return a == b;
            4'd1:    return a != b;
            4'd2:    return $signed(a) <= 0;
            4'd3:    return $signed(a) > 0;
            4'd4:    return $signed(a) < 0;
            4'd5:    return $signed(a) >= 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic s, input logic r,
                             input logic [31:0] rpc, input logic f, input logic d);
        chk({tag, ".stall"},       32'(stall1), 32'(s));
        chk({tag, ".stall_ns"},    32'(stall0), 32'(s));
        chk({tag, ".redirect"},    32'(redir1), 32'(r));
        chk({tag, ".redirect_ns"}, 32'(redir0), 32'(r));
        chk({tag, ".rpc"},         rpc1, rpc);
        chk({tag, ".rpc_ns"},      rpc0, rpc);
        chk({tag, ".flush_ds"},    32'(flush1), 32'd0);
        chk({tag, ".flush_ns"},    32'(flush0), 32'(f));
        chk({tag, ".done"},        32'(done1), 32'(d));
        chk({tag, ".done_ns"},     32'(done0), 32'(d));
        chk({tag, ".hto"},         32'(hto1), 32'(exp_hto));
        chk({tag, ".hto_ns"},      32'(hto0), 32'(exp_hto));
`ifdef BRANCH_STATS_EN
        chk({tag, ".total"},       32'(tot1), 32'(exp_total));
        chk({tag, ".taken"},       32'(tkn1), 32'(exp_tkn));
        chk({tag, ".total_ns"},    32'(tot0), 32'(exp_total));
        chk({tag, ".taken_ns"},    32'(tkn0), 32'(exp_tkn));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One branch from its first ID cycle through the cycle after its pulses.
    task automatic do_branch(input string tag, input logic [3:0] bt, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [31:0] pc, input logic [15:0] imm,
                             input int nwait, input bit abort, input bit rst_mid);
        logic        tk;
        logic [31:0] tgt;
        bit          rs_blk;
        tk  = model_taken(bt, rs, rt);
        tgt = pc + 32'($signed(imm)) * 32'd4;
        wait_elapsed = 0;
        for (int k = 0; k <= nwait; k++) begin
            tick();
            br_valid = !(abort && (k == nwait));
            btype    = bt;
            pc_plus4 = pc;
            imm16    = imm;
            if (k < nwait || abort) begin
                rs_blk   = (bt >= 4'd2) ? 1'b1 : 1'($urandom_range(0, 1));
                rs_ready = !rs_blk;
                rt_ready = rs_blk ? 1'($urandom_range(0, 1)) : 1'b0;
                rs_data  = $urandom;
                rt_data  = $urandom;
            end else begin
                rs_ready = 1'b1;
                rt_ready = (bt >= 4'd2) ? 1'($urandom_range(0, 1)) : 1'b1;
                rs_data  = rs;
                rt_data  = rt;
            end
            #2;
            check_all({tag, ".hold"}, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
            if (k >= 1 && k < nwait) begin
                wait_elapsed++;
                if (wait_elapsed >= MAX_WAIT) exp_hto = 1'b1;
            end
        end
        if (abort) begin
            for (int j = 0; j < 2; j++) begin
                tick();
                br_valid = 1'b0;
                rs_data  = $urandom;
                #2;
                check_all({tag, ".abort"}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            end
            return;
        end
        tick();
        br_valid = 1'($urandom_range(0, 1));
        rs_data  = $urandom;
        rt_data  = $urandom;
        rs_ready = 1'($urandom_range(0, 1));
        #2;
        check_all({tag, ".resolve"}, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        if (rst_mid) begin
            br_valid = 1'b0;
            #1 reset = 1'b1;
            #1;
            exp_hto = 1'b0;
`ifdef BRANCH_STATS_EN
            exp_total = 16'd0;
            exp_tkn   = 16'd0;
`endif
            check_all({tag, ".rst_now"}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            tick();
            #2;
            check_all({tag, ".rst_hold"}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            reset = 1'b0;
            tick();
            #2;
            check_all({tag, ".rst_after"}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
            return;
        end
`ifdef BRANCH_STATS_EN
        if (exp_total != 16'hFFFF) exp_total++;
        if (tk && exp_tkn != 16'hFFFF) exp_tkn++;
`endif
        tick();
        br_valid = 1'($urandom_range(0, 1));
        #2;
        check_all({tag, ".done"}, 1'b0, tk, tk ? tgt : 32'd0, tk, 1'b1);
        tick();
        br_valid = 1'b0;
        #2;
        check_all({tag, ".after"}, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [3:0]  bt;
        logic [31:0] rs, rt;
        int          nw;
        bit          ab;

        reset    = 1'b1;
        br_valid = 1'b0;
        btype    = 4'd0;
        rs_data  = 32'd0;
        rt_data  = 32'd0;
        rs_ready = 1'b0;
        rt_ready = 1'b0;
        pc_plus4 = 32'd0;
        imm16    = 16'd0;
        exp_hto  = 1'b0;
`ifdef BRANCH_STATS_EN
        exp_total = 16'd0;
        exp_tkn   = 16'd0;
`endif
        #2;
        check_all("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #2;
        check_all("idle", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        do_branch("beq_taken", 4'd0, 32'h5, 32'h5, 32'h100, 16'h0004, 0, 1'b0, 1'b0);
        do_branch("bne_equal", 4'd1, 32'h7, 32'h7, 32'h200, 16'h0010, 0, 1'b0, 1'b0);
        do_branch("bgtz_wait", 4'd3, 32'h1, 32'h0, 32'h300, 16'hFFFC, 5, 1'b0, 1'b0);
        do_branch("wait_abort", 4'd0, 32'h9, 32'h9, 32'h400, 16'h0002, 2, 1'b1, 1'b0);
        do_branch("bltz_wrap", 4'd4, 32'h8000_0000, 32'h0, 32'hFFFF_FFFC, 16'h0001, 0, 1'b0, 1'b0);
        do_branch("blez_zero", 4'd2, 32'h0, 32'h1234, 32'h500, 16'h8000, 1, 1'b0, 1'b0);
        do_branch("bgez_neg", 4'd5, 32'hFFFF_FFFF, 32'h0, 32'h600, 16'h0003, 0, 1'b0, 1'b0);
        do_branch("code_other", 4'd9, 32'h0, 32'h0, 32'h700, 16'h0001, 0, 1'b0, 1'b0);
        do_branch("long_wait", 4'd1, 32'h1, 32'h2, 32'h800, 16'h0005, 18, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bt = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = 32'h8000_0000 | $urandom;
                2:       rs = $urandom;
                default: rs = 32'($urandom_range(0, 3));
            endcase
            rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
            nw = $urandom_range(0, 4);
            ab = (nw > 0) && ($urandom_range(0, 5) == 0);
            do_branch("rand", bt, rs, rt, $urandom, 16'($urandom), nw, ab, 1'b0);
        end

        do_branch("rst_resolve", 4'd0, 32'h3, 32'h3, 32'h900, 16'h0004, 4, 1'b0, 1'b1);
        do_branch("post_reset", 4'd0, 32'h5, 32'h5, 32'h100, 16'h0004, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
